data_mem_arbiter: RTL and testbench

//  Shares the single-port data memory between NUM_REQ requesters (core LSU, debug/DMA) with round-robin arbitration.

---
 rtl/data_mem_arb_pkg.sv | 29 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/data_mem_arbiter.sv | 113 +++++++++++
 tb/tb_data_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM state encoding and
// the byte-lane merge used by read-modify-write stores.
package data_mem_arb_pkg;

  localparam int DATA_W = 32;
  localparam int BYTES  = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    WRITE,
    RESP
  } state_t;

  // Lane k takes the new byte when be[k] is set, otherwise keeps the old byte.
  function automatic logic [DATA_W-1:0] merge_bytes(
    input logic [DATA_W-1:0] old_w,
    input logic [DATA_W-1:0] new_w,
    input logic [BYTES-1:0]  be
  );
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int k = 0; k < BYTES; k++) begin
      if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the search starts at the pointer
// and the pointer moves just past the winner only when the grant is taken.
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         i_valid,
  input  logic                       i_accept,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_idx,
  output logic                       o_any
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int W1 = IW + 1;

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_idx;
  logic [W1-1:0] w_sum;
  logic          w_any;

  // Scan offsets from far to near so the nearest valid requester wins.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_sum = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      w_sum = {1'b0, r_ptr} + W1'(i);
      if (w_sum >= W1'(NUM_REQ)) w_sum = w_sum - W1'(NUM_REQ);
      if (i_valid[w_sum[IW-1:0]]) begin
        w_any = 1'b1;
        w_idx = w_sum[IW-1:0];
      end
    end
  end

  assign o_any       = w_any;
  assign o_grant_idx = w_idx;
  assign o_grant     = w_any ? (NUM_REQ'(1) << w_idx) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (i_accept && w_any) begin
      r_ptr <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares a single-port data memory between NUM_REQ requesters and turns
// byte-masked stores into read-modify-write sequences on whole-word writes.
module data_mem_arbiter
  import data_mem_arb_pkg::*;
#(
  parameter int N       = DATA_W,
  parameter int NUM_REQ = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*N-1:0]   req_addr,
  input  logic [NUM_REQ-1:0]     req_we,
  input  logic [NUM_REQ*N-1:0]   req_wdata,
  input  logic [NUM_REQ*N/8-1:0] req_be,
  output logic [NUM_REQ-1:0]     resp_valid,
  output logic [N-1:0]           resp_rdata,
  output logic [N-1:0]           mem_addr,
  output logic                   mem_write_enable,
  output logic [N-1:0]           mem_write_data,
  input  logic [N-1:0]           mem_read_data
);
  localparam int NB = N / 8;
  localparam int IW = $clog2(NUM_REQ);

  state_t             r_state, w_next;
  logic [N-1:0]       r_addr, r_wdata, r_rdata;
  logic [NB-1:0]      r_be;
  logic               r_we;
  logic [IW-1:0]      r_id;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]      w_grant_idx;
  logic               w_any, w_idle, w_full, w_none;

  assign w_idle = (r_state == IDLE);
  assign w_full = &r_be;
  assign w_none = ~|r_be;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (req_valid),
    .i_accept   (w_idle),
    .o_grant    (w_grant),
    .o_grant_idx(w_grant_idx),
    .o_any      (w_any)
  );

  // Ready is gated by reset directly so it drops the instant reset asserts.
  assign req_ready  = (w_idle && rst) ? w_grant : '0;
  assign mem_addr   = r_addr;
  assign resp_rdata = r_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_we    <= 1'b0;
      r_id    <= '0;
      r_rdata <= '0;
    end else begin
      if (w_idle && w_any) begin
        r_addr  <= req_addr[w_grant_idx*N +: N];
        r_wdata <= req_wdata[w_grant_idx*N +: N];
        r_be    <= req_be[w_grant_idx*NB +: NB];
        r_we    <= req_we[w_grant_idx];
        r_id    <= w_grant_idx;
      end
      if (r_state == ACCESS) r_rdata <= mem_read_data;
    end
  end

  always_comb begin
    w_next           = r_state;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    resp_valid       = '0;
    case (r_state)
      IDLE: begin
        if (w_any) w_next = ACCESS;
      end
      ACCESS: begin
        if (r_we && w_full) begin
          mem_write_enable = 1'b1;
          mem_write_data   = r_wdata;
          w_next           = RESP;
        end else if (r_we && !w_none) begin
          w_next = WRITE;
        end else begin
          w_next = RESP;
        end
      end
      WRITE: begin
        mem_write_enable = 1'b1;
        mem_write_data   = merge_bytes(r_rdata, r_wdata, r_be);
        w_next           = RESP;
      end
      RESP: begin
        resp_valid[r_id] = 1'b1;
        w_next           = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: transaction-timeline reference
// model compared every cycle, directed scenarios, then randomized traffic.
module tb_data_mem_arbiter;
  localparam int N  = 32;
  localparam int NR = 2;
  localparam int NB = N / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid, req_ready, req_we, resp_valid;
  logic [NR*N-1:0]  req_addr, req_wdata;
  logic [NR*NB-1:0] req_be;
  logic [N-1:0]     resp_rdata, mem_addr, mem_write_data, mem_read_data;
  logic             mem_write_enable;

  data_mem_arbiter #(.N(N), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // 16-word memory with combinational read; preload port for the bench
  logic [31:0] mem [16];
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  assign mem_read_data = mem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_write_enable) mem[mem_addr[5:2]] <= mem_write_data;
  end

  // requester payloads, held until accepted
  logic        pend[NR];
  logic [31:0] p_addr[NR], p_wdata[NR];
  logic        p_we[NR];
  logic [3:0]  p_be[NR];

  // reference model state
  logic [31:0] ref_mem[16];
  int          m_ptr, m_age, m_id, m_done_age;
  bit          m_busy;
  logic [31:0] m_addr, m_wdata, m_old, m_rdata;
  logic        m_we;
  logic [3:0]  m_be;

  int n_tests = 0, n_fail = 0, cyc = 0;
  int acc_cyc, acc_id, resp_cyc, resp_id, wr_cnt, wr_cyc, overlap;
  logic [31:0] resp_data, wr_data;
  int grant_log[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                            input logic [3:0] be);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    return r;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]          = pend[i];
      req_addr[i*N +: N]    = p_addr[i];
      req_wdata[i*N +: N]   = p_wdata[i];
      req_we[i]             = p_we[i];
      req_be[i*NB +: NB]    = p_be[i];
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic we,
                         input logic [31:0] d, input logic [3:0] be);
    pend[i] = 1'b1; p_addr[i] = a; p_we[i] = we; p_wdata[i] = d; p_be[i] = be;
  endtask

  // One clock: compare at negedge, then advance the model after posedge.
  task automatic step();
    logic [1:0]  e_ready, e_resp;
    logic        e_we, full, partial;
    logic [31:0] e_wd;
    int g;
    @(negedge clk);
    if (!rst) begin
      m_busy = 0; m_ptr = 0; m_addr = '0; m_rdata = '0;
    end
    full    = m_we && (m_be == 4'hF);
    partial = m_we && (m_be != 4'h0) && (m_be != 4'hF);
    g = -1;
    e_ready = '0;
    if (rst && !m_busy)
      for (int i = 0; i < NR; i++) begin
        int j;
        j = (m_ptr + i) % NR;
        if (g < 0 && req_valid[j]) g = j;
      end
    if (g >= 0) e_ready[g] = 1'b1;
    e_we   = m_busy && ((full && m_age == 1) || (partial && m_age == 2));
    e_wd   = !e_we ? 32'h0 : (full ? m_wdata : exp_merge(m_old, m_wdata, m_be));
    e_resp = (m_busy && m_age == m_done_age) ? (2'b01 << m_id) : 2'b00;
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("mem_write_enable", 32'(mem_write_enable), 32'(e_we));
    check("mem_write_data", mem_write_data, e_wd);
    check("mem_addr", mem_addr, m_addr);
    check("resp_valid", 32'(resp_valid), 32'(e_resp));
    check("resp_rdata", resp_rdata, m_rdata);
    // observations of the DUT for directed literal checks
    if (|req_ready) begin acc_cyc = cyc; acc_id = req_ready[1] ? 1 : 0; end
    if (|resp_valid) begin
      resp_cyc = cyc; resp_id = resp_valid[1] ? 1 : 0; resp_data = resp_rdata;
      if (resp_valid == 2'b11) overlap++;
    end
    if (mem_write_enable) begin wr_cnt++; wr_cyc = cyc; wr_data = mem_write_data; end
    if (g >= 0) begin
      m_busy = 1; m_age = 0; m_id = g;
      m_addr = req_addr[g*N +: N]; m_wdata = req_wdata[g*N +: N];
      m_we = req_we[g]; m_be = req_be[g*NB +: NB];
      m_old = ref_mem[m_addr[5:2]];
      m_done_age = (m_we && m_be != 4'h0 && m_be != 4'hF) ? 3 : 2;
      m_ptr = (g + 1) % NR;
      grant_log.push_back(g);
      pend[g] = 1'b0;
    end
    @(posedge clk);
    cyc++;
    if (e_we) ref_mem[m_addr[5:2]] = e_wd;
    if (pre_en) ref_mem[pre_idx] = pre_val;
    if (m_busy && m_age == 1) m_rdata = m_old;
    if (m_busy) begin
      if (m_age == m_done_age) m_busy = 0;
      else m_age++;
    end
    #1;
    pre_en = 1'b0;
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    pre_en = 1'b1; pre_idx = 4'(idx); pre_val = v;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    drive_inputs();
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic run_txn(input int budget);
    int t0;
    t0 = resp_cyc;
    drive_inputs();
    for (int k = 0; k < budget; k++) begin
      step();
      drive_inputs();
      if (resp_cyc != t0 && !m_busy) break;
    end
    n_tests++;
    if (resp_cyc == t0 || m_busy) begin
      n_fail++;
      $display("FAIL txn_timeout: got no response, required one within %0d cycles", budget);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, t;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 0; p_addr[i] = 0; p_wdata[i] = 0; p_we[i] = 0; p_be[i] = 0;
    end
    m_ptr = 0; m_busy = 0; m_age = 0; m_id = 0; m_done_age = 2;
    m_addr = 0; m_wdata = 0; m_old = 0; m_rdata = 0; m_we = 0; m_be = 0;
    acc_cyc = -1; acc_id = -1; resp_cyc = -1; resp_id = -1; wr_cnt = 0; wr_cyc = -1;
    overlap = 0; resp_data = 0; wr_data = 0;
    rst = 1'b0;
    drive_inputs();
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    repeat (2) step();
    check("reset_ready", 32'(req_ready), 32'h0);
    check("reset_rdata", resp_rdata, 32'h0);
    rst = 1'b1;
    step();

    // 1: load
    preload(4, 32'hDEADBEEF);
    w0 = wr_cnt;
    set_req(0, 32'h10, 1'b0, 32'h0, 4'h0);
    run_txn(10);
    t = acc_cyc;
    check("t1_grant", acc_id, 0);
    check("t1_lat", resp_cyc - t, 2);
    check("t1_id", resp_id, 0);
    check("t1_data", resp_data, 32'hDEADBEEF);
    check("t1_nowrite", wr_cnt - w0, 0);

    // 2: full store
    w0 = wr_cnt;
    set_req(1, 32'h08, 1'b1, 32'h12345678, 4'hF);
    run_txn(10);
    t = acc_cyc;
    check("t2_wr_lat", wr_cyc - t, 1);
    check("t2_wr_cnt", wr_cnt - w0, 1);
    check("t2_wr_data", wr_data, 32'h12345678);
    check("t2_mem", mem[2], 32'h12345678);
    check("t2_lat", resp_cyc - t, 2);
    check("t2_id", resp_id, 1);

    // 3: partial store
    preload(1, 32'h11223344);
    set_req(0, 32'h04, 1'b1, 32'h000000AA, 4'b0001);
    run_txn(10);
    t = acc_cyc;
    check("t3_wr_lat", wr_cyc - t, 2);
    check("t3_wr_data", wr_data, 32'h112233AA);
    check("t3_lat", resp_cyc - t, 3);
    check("t3_rdata", resp_data, 32'h11223344);
    check("t3_mem", mem[1], 32'h112233AA);

    // 4: continuous contention from pointer 0
    do_reset();
    grant_log.delete();
    overlap = 0;
    for (int k = 0; k < 40 && grant_log.size() < 4; k++) begin
      if (!pend[0]) set_req(0, 32'h20, 1'b0, 32'h0, 4'h0);
      if (!pend[1]) set_req(1, 32'h24, 1'b0, 32'h0, 4'h0);
      drive_inputs();
      step();
    end
    pend[0] = 0; pend[1] = 0;
    drive_inputs();
    repeat (4) step();
    check("t4_count", grant_log.size(), 4);
    for (int k = 0; k < 4 && k < grant_log.size(); k++)
      check($sformatf("t4_grant%0d", k), grant_log[k], k % 2);
    check("t4_overlap", overlap, 0);

    // 5: null store
    w0 = wr_cnt;
    set_req(1, 32'h08, 1'b1, 32'hFFFFFFFF, 4'h0);
    run_txn(10);
    t = acc_cyc;
    check("t5_nowrite", wr_cnt - w0, 0);
    check("t5_lat", resp_cyc - t, 2);
    check("t5_mem", mem[2], 32'h12345678);

    // 6: reset during the write phase of a partial store from req0
    preload(3, 32'hCAFEF00D);
    set_req(0, 32'h0C, 1'b1, 32'h55555555, 4'b0110);
    drive_inputs();
    step();
    drive_inputs();
    step();
    t = resp_cyc;
    #1;
    check("t6_in_write", 32'(mem_write_enable), 32'h1);
    rst = 1'b0;
    #1;
    check("t6_we_drop", 32'(mem_write_enable), 32'h0);
    pend[0] = 0;
    drive_inputs();
    repeat (2) step();
    rst = 1'b1;
    repeat (3) step();
    check("t6_noresp", resp_cyc, t);
    check("t6_mem", mem[3], 32'hCAFEF00D);
    set_req(0, 32'h0C, 1'b0, 32'h0, 4'h0);
    set_req(1, 32'h0C, 1'b0, 32'h0, 4'h0);
    run_txn(10);
    check("t6_grant", acc_id, 0);
    check("t6_rdata", resp_data, 32'hCAFEF00D);
    pend[1] = 0;
    drive_inputs();
    repeat (4) step();

    // randomized traffic, model compared every cycle
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          logic [3:0] be;
          case ($urandom_range(0, 3))
            0: be = 4'h0;
            1: be = 4'hF;
            default: be = 4'($urandom_range(0, 15));
          endcase
          set_req(i, {26'h0, 4'($urandom_range(0, 15)), 2'b00}, 1'($urandom_range(0, 1)),
                  $urandom, be);
        end else if (pend[i] && $urandom_range(0, 19) == 0) begin
          pend[i] = 1'b0;
        end
      end
      drive_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
